// File: rtl/qspi_reg_pkg.sv
// rtl/qspi_reg_pkg.sv - QSPI register bank offsets, AHB encodings, field positions
package qspi_reg_pkg;

    localparam logic [7:0] QSPI_CTRL_OFS   = 8'h00;
    localparam logic [7:0] QSPI_CLKDIV_OFS = 8'h04;
    localparam logic [7:0] QSPI_STATUS_OFS = 8'h08;
    localparam logic [7:0] QSPI_CMD_OFS    = 8'h0C;
    localparam logic [7:0] QSPI_ADDR_OFS   = 8'h10;
    localparam logic [7:0] QSPI_LEN_OFS    = 8'h14;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'd0,
        MODE_DUAL   = 2'd1,
        MODE_QUAD   = 2'd2
    } qspi_mode_e;

    localparam int CTRL_START_BIT = 2;
    localparam int CTRL_IE_BIT    = 3;
    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_DONE_BIT  = 1;

    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/qspi_ahb_lane_dec.sv
// rtl/qspi_ahb_lane_dec.sv - AHB size/offset to byte-lane mask with misalignment flag
module qspi_ahb_lane_dec (
    input  logic [2:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] lanes,
    output logic       misalign
);

    // Unsupported sizes (>word) are folded into misalign so callers see one error flag.
    always_comb begin
        lanes    = '0;
        misalign = 1'b0;
        case (size)
            3'd0: lanes = 4'b0001 << addr_lo;
            3'd1: begin
                if (addr_lo[0]) misalign = 1'b1;
                else            lanes    = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            3'd2: begin
                if (addr_lo != 2'b00) misalign = 1'b1;
                else                  lanes    = 4'b1111;
            end
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/qspi_ahb_regbank.sv
// rtl/qspi_ahb_regbank.sv - AHB-lite slave register bank for the QSPI controller
module qspi_ahb_regbank
    import qspi_reg_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DIV_W   = 8,
    parameter int LEN_W   = 16,
    parameter int DIV_RST = 1
) (
    input  logic             h_clk,
    input  logic             h_rstn,
    input  logic             h_sel,
    input  logic [1:0]       h_trans,
    input  logic             h_write,
    input  logic [2:0]       h_size,
    input  logic [31:0]      h_addr,
    input  logic [31:0]      h_wdata,
    output logic             h_ready,
    output logic [1:0]       h_resp,
    output logic [31:0]      h_rdata,
    output logic [1:0]       cfg_mode,
    output logic             cfg_ie,
    output logic [DIV_W-1:0] cfg_clk_div,
    output logic [7:0]       cfg_cmd,
    output logic [31:0]      cfg_addr,
    output logic [LEN_W-1:0] cfg_len,
    output logic             start,
    input  logic             core_busy,
    input  logic             core_done,
    output logic             irq
);

    typedef enum logic {ST_OKAY, ST_ERR2} dp_state_e;
    dp_state_e state_q, state_d;

    logic [3:0]        ap_lanes;
    logic              ap_misalign;
    logic [ADDR_W-1:0] ap_ofs;
    logic              ap_accept;
    logic              unused_bits;

    qspi_ahb_lane_dec u_lane_dec (
        .size     (h_size),
        .addr_lo  (h_addr[1:0]),
        .lanes    (ap_lanes),
        .misalign (ap_misalign)
    );

    assign ap_ofs      = {h_addr[ADDR_W-1:2], 2'b00};
    assign ap_accept   = h_sel & h_trans[1] & h_ready;
    assign unused_bits = ^{h_addr[31:ADDR_W], h_trans[0]};

    logic              dp_valid, dp_write, dp_bad;
    logic [3:0]        dp_be;
    logic [ADDR_W-1:0] dp_ofs;

    logic [1:0]       mode_q;
    logic             ie_q, done_q, start_q, irq_q;
    logic [DIV_W-1:0] clk_div_q;
    logic [7:0]       cmd_q;
    logic [31:0]      addr_q;
    logic [LEN_W-1:0] len_q;

    logic is_ctrl, is_div, is_stat, is_cmd, is_addr, is_len;
    assign is_ctrl = dp_ofs == ADDR_W'(QSPI_CTRL_OFS);
    assign is_div  = dp_ofs == ADDR_W'(QSPI_CLKDIV_OFS);
    assign is_stat = dp_ofs == ADDR_W'(QSPI_STATUS_OFS);
    assign is_cmd  = dp_ofs == ADDR_W'(QSPI_CMD_OFS);
    assign is_addr = dp_ofs == ADDR_W'(QSPI_ADDR_OFS);
    assign is_len  = dp_ofs == ADDR_W'(QSPI_LEN_OFS);

    // Engine config is frozen while busy; any CTRL lane-0 write touches mode/start.
    logic lock_hit, stat_ro_only, dp_err, commit;
    assign lock_hit     = core_busy & (is_div | is_cmd | is_addr | is_len | (is_ctrl & dp_be[0]));
    assign stat_ro_only = is_stat & dp_be[0] & h_wdata[STAT_BUSY_BIT] & ~h_wdata[STAT_DONE_BIT];
    assign dp_err       = dp_valid & (dp_bad | (dp_write & (lock_hit | stat_ro_only)));

    always_comb begin
        state_d = state_q;
        h_ready = 1'b1;
        h_resp  = HRESP_OKAY;
        commit  = 1'b0;
        case (state_q)
            ST_OKAY: begin
                if (dp_err) begin
                    h_ready = 1'b0;
                    h_resp  = HRESP_ERROR;
                    state_d = ST_ERR2;
                end else begin
                    commit = dp_valid & dp_write;
                end
            end
            ST_ERR2: begin
                h_resp  = HRESP_ERROR;
                state_d = ST_OKAY;
            end
            default: state_d = ST_OKAY;
        endcase
    end

    logic [31:0] rd_word;
    always_comb begin
        rd_word = '0;
        if (is_ctrl) begin
            rd_word[1:0]        = mode_q;
            rd_word[CTRL_IE_BIT] = ie_q;
        end else if (is_div) begin
            rd_word[DIV_W-1:0] = clk_div_q;
        end else if (is_stat) begin
            rd_word[STAT_BUSY_BIT] = core_busy;
            rd_word[STAT_DONE_BIT] = done_q;
        end else if (is_cmd) begin
            rd_word[7:0] = cmd_q;
        end else if (is_addr) begin
            rd_word = addr_q;
        end else if (is_len) begin
            rd_word[LEN_W-1:0] = len_q;
        end
        h_rdata = (dp_valid & ~dp_write & ~dp_err) ? rd_word : '0;
    end

    always_ff @(posedge h_clk) begin
        if (!h_rstn) begin
            state_q   <= ST_OKAY;
            dp_valid  <= 1'b0;
            dp_write  <= 1'b0;
            dp_bad    <= 1'b0;
            dp_be     <= '0;
            dp_ofs    <= '0;
            mode_q    <= MODE_SINGLE;
            ie_q      <= 1'b0;
            clk_div_q <= DIV_W'(DIV_RST);
            cmd_q     <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            done_q    <= 1'b0;
            start_q   <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            // An address phase seen while the first ERROR cycle stalls the bus is dropped.
            if (h_ready) begin
                dp_valid <= ap_accept;
                dp_write <= h_write;
                dp_be    <= ap_lanes;
                dp_ofs   <= ap_ofs;
                dp_bad   <= ap_misalign | (ap_ofs > ADDR_W'(QSPI_LEN_OFS));
            end else begin
                dp_valid <= 1'b0;
            end
            start_q <= commit & is_ctrl & dp_be[0] & h_wdata[CTRL_START_BIT];
            if (commit & is_ctrl & dp_be[0]) begin
                mode_q <= h_wdata[1:0];
                ie_q   <= h_wdata[CTRL_IE_BIT];
            end
            if (commit & is_div)
                clk_div_q <= DIV_W'(be_merge(32'(clk_div_q), h_wdata, dp_be));
            if (commit & is_cmd & dp_be[0])
                cmd_q <= h_wdata[7:0];
            if (commit & is_addr)
                addr_q <= be_merge(addr_q, h_wdata, dp_be);
            if (commit & is_len)
                len_q <= LEN_W'(be_merge(32'(len_q), h_wdata, dp_be));
            // Set beats clear when both land on the same edge.
            done_q <= core_done |
                      (done_q & ~(commit & is_stat & dp_be[0] & h_wdata[STAT_DONE_BIT]));
            irq_q  <= done_q & ie_q;
        end
    end

    assign cfg_mode    = mode_q;
    assign cfg_ie      = ie_q;
    assign cfg_clk_div = clk_div_q;
    assign cfg_cmd     = cmd_q;
    assign cfg_addr    = addr_q;
    assign cfg_len     = len_q;
    assign start       = start_q;
    assign irq         = irq_q;

endmodule
